// File: rtl/cpu_pkg.sv
// ============================================================================
// cpu_pkg : opcodes, FSM state encoding, fault codes and strobe bundle. Rev 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_MEM_TMO = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4   = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_HALT = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        CL_REG, CL_IMM, CL_MULDIV, CL_MFHI, CL_MFLO,
        CL_UNARY, CL_NOP, CL_HALT, CL_ILLEGAL
    } iclass_t;

    typedef struct packed {
        logic gra, grb, grc, rin, rout, baout;
        logic hiout, loout, zhiout, zloout, pcout, mdrout, inportout, cout;
        logic pcin, irin, marin, mdrin, yin, zin, hiin, loin, incpc, read;
    } strobes_t;

    function automatic iclass_t op_class(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:        return CL_REG;
            OP_ADDI, OP_ANDI, OP_ORI:               return CL_IMM;
            OP_MUL, OP_DIV:                         return CL_MULDIV;
            OP_MFHI:                                return CL_MFHI;
            OP_MFLO:                                return CL_MFLO;
            OP_NEG, OP_NOT:                         return CL_UNARY;
            OP_NOP:                                 return CL_NOP;
            OP_HALT:                                return CL_HALT;
            default:                                return CL_ILLEGAL;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ============================================================================
// ctrl_decode : combinational (state, opcode) -> control strobe bundle. Rev 1.0
// ============================================================================
`default_nettype none

module ctrl_decode
    import cpu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  state_t         state,
    input  logic           first_t1,
    input  logic [OPW-1:0] opcode,
    output strobes_t       strobes,
    output logic [OPW-1:0] alu_op
);

    iclass_t cls;
    assign cls = op_class(opcode);

    always_comb begin
        strobes = '0;
        alu_op  = '0;
        case (state)
            S_T0: begin
                strobes.pcout = 1'b1;
                strobes.marin = 1'b1;
                strobes.incpc = 1'b1;
                strobes.zin   = 1'b1;
            end
            S_T1: begin
                // PC reloads once; the memory read stays requested while waiting
                strobes.zloout = 1'b1;
                strobes.pcin   = first_t1;
                strobes.read   = 1'b1;
                strobes.mdrin  = 1'b1;
            end
            S_T2: begin
                strobes.mdrout = 1'b1;
                strobes.irin   = 1'b1;
            end
            S_T3: begin
                alu_op = opcode;
                case (cls)
                    CL_REG, CL_IMM: begin
                        strobes.grb = 1'b1; strobes.rout = 1'b1; strobes.yin = 1'b1;
                    end
                    CL_MULDIV: begin
                        strobes.gra = 1'b1; strobes.rout = 1'b1; strobes.yin = 1'b1;
                    end
                    CL_MFHI: begin
                        strobes.hiout = 1'b1; strobes.gra = 1'b1; strobes.rin = 1'b1;
                    end
                    CL_MFLO: begin
                        strobes.loout = 1'b1; strobes.gra = 1'b1; strobes.rin = 1'b1;
                    end
                    CL_UNARY: begin
                        strobes.grb = 1'b1; strobes.rout = 1'b1; strobes.zin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                alu_op = opcode;
                case (cls)
                    CL_REG: begin
                        strobes.grc = 1'b1; strobes.rout = 1'b1; strobes.zin = 1'b1;
                    end
                    CL_IMM: begin
                        strobes.cout = 1'b1; strobes.zin = 1'b1;
                    end
                    CL_MULDIV: begin
                        strobes.grb = 1'b1; strobes.rout = 1'b1; strobes.zin = 1'b1;
                    end
                    CL_UNARY: begin
                        strobes.zloout = 1'b1; strobes.gra = 1'b1; strobes.rin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                alu_op = opcode;
                case (cls)
                    CL_REG, CL_IMM: begin
                        strobes.zloout = 1'b1; strobes.gra = 1'b1; strobes.rin = 1'b1;
                    end
                    CL_MULDIV: begin
                        strobes.zloout = 1'b1; strobes.loin = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                alu_op         = opcode;
                strobes.zhiout = 1'b1;
                strobes.hiin   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
// control_sequencer : Moore control FSM (fetch/execute, mem wait, halt/fault).
// Option macro CTRL_ILLEGAL_TRAP_EN traps unlisted opcodes.           Rev 1.0
// ============================================================================
`default_nettype none

module control_sequencer
    import cpu_pkg::*;
#(
    parameter int OPW          = 5,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic           clock,
    input  logic           clear,
    input  logic [31:0]    ir,
    input  logic           mem_rdy,
    input  logic           run_req,
    output logic           Gra, Grb, Grc,
    output logic           Rin, Rout, BAout,
    output logic           HIout, LOout, ZHIout, ZLOout, PCout, MDRout, Inportout, Cout,
    output logic           PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, IncPC, Read,
    output logic [OPW-1:0] alu_op,
    output logic           run,
    output logic [1:0]     fault
);

    localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);

    state_t           state, next_state, end_state;
    logic [CNT_W-1:0] wait_cnt, next_cnt;
    logic [1:0]       fault_q, next_fault;
    logic [OPW-1:0]   opcode;
    strobes_t         strobes;
    logic             unused_ir;

    assign opcode    = ir[31 -: OPW];
    assign unused_ir = ^ir[31-OPW:0];
    assign end_state = run_req ? S_T0 : S_IDLE;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            fault_q  <= FAULT_NONE;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
            fault_q  <= next_fault;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = wait_cnt;
        next_fault = fault_q;
        case (state)
            S_IDLE: if (run_req) next_state = S_T0;
            S_T0: begin
                next_state = S_T1;
                next_cnt   = '0;
            end
            S_T1: begin
                if (mem_rdy) begin
                    next_state = S_T2;
                    next_cnt   = '0;
                end else if (wait_cnt == CNT_W'(MEM_WAIT_MAX - 1)) begin
                    next_state = S_HALT;
                    next_fault = FAULT_MEM_TMO;
                end else begin
                    next_cnt = wait_cnt + CNT_W'(1);
                end
            end
            S_T2: next_state = S_T3;
            S_T3: begin
                case (op_class(opcode))
                    CL_REG, CL_IMM, CL_MULDIV, CL_UNARY: next_state = S_T4;
                    CL_HALT:                             next_state = S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    CL_ILLEGAL: begin
                        next_state = S_HALT;
                        next_fault = FAULT_ILLEGAL;
                    end
`endif
                    default:                             next_state = end_state;
                endcase
            end
            S_T4: next_state = (op_class(opcode) == CL_UNARY) ? end_state : S_T5;
            S_T5: next_state = (op_class(opcode) == CL_MULDIV) ? S_T6 : end_state;
            S_T6: next_state = end_state;
            S_HALT: next_state = S_HALT;
            default: next_state = S_IDLE;
        endcase
    end

    ctrl_decode #(.OPW(OPW)) u_decode (
        .state    (state),
        .first_t1 (wait_cnt == '0),
        .opcode   (opcode),
        .strobes  (strobes),
        .alu_op   (alu_op)
    );

    assign Gra       = strobes.gra;
    assign Grb       = strobes.grb;
    assign Grc       = strobes.grc;
    assign Rin       = strobes.rin;
    assign Rout      = strobes.rout;
    assign BAout     = strobes.baout;
    assign HIout     = strobes.hiout;
    assign LOout     = strobes.loout;
    assign ZHIout    = strobes.zhiout;
    assign ZLOout    = strobes.zloout;
    assign PCout     = strobes.pcout;
    assign MDRout    = strobes.mdrout;
    assign Inportout = strobes.inportout;
    assign Cout      = strobes.cout;
    assign PCin      = strobes.pcin;
    assign IRin      = strobes.irin;
    assign MARin     = strobes.marin;
    assign MDRin     = strobes.mdrin;
    assign Yin       = strobes.yin;
    assign Zin       = strobes.zin;
    assign HIin      = strobes.hiin;
    assign LOin      = strobes.loin;
    assign IncPC     = strobes.incpc;
    assign Read      = strobes.read;
    assign run       = (state != S_HALT);
    assign fault     = fault_q;

endmodule

`default_nettype wire
